hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core: it drives the stall, flush and forward-select inputs of the datapath. It resolves RAW hazards by forwarding from M/W and stalls one cycle for load-use. It flushes wrong-path instructions on taken branches and jumps. It also freezes the pipeline while data memory is not ready, using a wait-state FSM with a timeout trap.

---
 rtl/hazard_if.sv | 42 ++++
 rtl/hazard_unit.sv | 136 +++++++++++++
 tb/tb_hazard_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Signal bundle between the datapath and the pipeline hazard controller.
// The datapath side uses the master modport; the hazard unit uses slave.
interface hazard_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       PCSrcE;
  logic       MemReqM;
  logic       MemReadyM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MemTimeout;
  logic [1:0] HzState;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RdM, RdW,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, HzState
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, RdM, RdW,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, HzState
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch flush and a
// data-memory wait FSM with timeout trap. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TRAP     = 2'b10
  } hz_state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  hz_state_t  state;
  logic [7:0] wcnt;
  logic       memTimeoutQ;
  logic       lwStall;
  logic       memStall;

  assign lwStall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign memStall = hz.MemReqM && !hz.MemReadyM;

  // Priority: reset, trap, memory wait, branch, load-use; forwarding is independent except under reset.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (reset) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
        hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
        hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
        hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
        hz.ForwardBE = 2'b01;

      if (state == TRAP || memStall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else if (hz.PCSrcE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lwStall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  // wcnt holds the number of consecutive wait cycles already seen; trap once it reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wcnt        <= 8'd0;
      memTimeoutQ <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state <= MEM_WAIT;
            wcnt  <= 8'd1;
          end else begin
            wcnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (!memStall) begin
            state <= RUN;
            wcnt  <= 8'd0;
          end else if (wcnt == TIMEOUT) begin
            state       <= TRAP;
            memTimeoutQ <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        TRAP: begin
          memTimeoutQ <= 1'b1;
        end
        default: begin
          state <= RUN;
          wcnt  <= 8'd0;
        end
      endcase
    end
  end

  assign hz.HzState    = state;
  assign hz.MemTimeout = memTimeoutQ;

`ifdef HAZARD_PERF_EN
  logic branchFlush;

  assign branchFlush = !reset && state != TRAP && !memStall && hz.PCSrcE;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (hz.StallF && StallCount != 32'hFFFF_FFFF)
        StallCount <= StallCount + 32'd1;
      if (branchFlush && FlushCount != 32'hFFFF_FFFF)
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver pushes model-predicted outputs, a negedge monitor
// pops and compares. Build with HAZARD_PERF_EN defined to also check the perf counters.
module tb_hazard_unit;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic       reset;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] resultsrce;
    logic       regwritem, regwritew, pcsrce, memreqm, memreadym;
  } stim_t;

  typedef struct {
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic [3:0]  stall;
    logic [2:0]  flush;
    logic        memtimeout;
    logic [1:0]  hzstate;
    logic [31:0] stallcount;
    logic [31:0] flushcount;
  } want_t;

  logic clk;
  logic reset;
  hazard_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;
`endif

  hazard_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount (stallCount),
    .FlushCount (flushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  want_t q[$];
  int checks = 0;
  int passes = 0;

  // Reference model state: consecutive memory-wait cycles seen so far and the sticky trap.
  int          streak  = 0;
  bit          trapped = 0;
  logic [31:0] mStalls = 0;
  logic [31:0] mFlushes = 0;

  function automatic logic [1:0] fwd(input logic [4:0] rs, input stim_t s);
    if (s.regwritem && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regwritew && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic applyStimulus(input stim_t s);
    want_t w;
    bit    memStall, lw, branch;
    @(posedge clk);
    #1;
    reset         = s.reset;
    hz.Rs1D       = s.rs1d;
    hz.Rs2D       = s.rs2d;
    hz.Rs1E       = s.rs1e;
    hz.Rs2E       = s.rs2e;
    hz.RdE        = s.rde;
    hz.RdM        = s.rdm;
    hz.RdW        = s.rdw;
    hz.ResultSrcE = s.resultsrce;
    hz.RegWriteM  = s.regwritem;
    hz.RegWriteW  = s.regwritew;
    hz.PCSrcE     = s.pcsrce;
    hz.MemReqM    = s.memreqm;
    hz.MemReadyM  = s.memreadym;

    memStall = s.memreqm && !s.memreadym;
    lw       = s.resultsrce == 2'b01 && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    branch   = 0;
    w.stall  = 4'b0000;
    w.flush  = 3'b000;
    w.fwda   = s.reset ? 2'b00 : fwd(s.rs1e, s);
    w.fwdb   = s.reset ? 2'b00 : fwd(s.rs2e, s);
    if (s.reset) w.flush = 3'b111;
    else if (trapped || memStall) begin
      w.stall = 4'b1111;
      w.flush = 3'b001;
    end else if (s.pcsrce) begin
      w.flush = 3'b110;
      branch  = 1;
    end else if (lw) begin
      w.stall = 4'b1100;
      w.flush = 3'b010;
    end
    w.memtimeout = trapped;
    w.hzstate    = trapped ? 2'b10 : (streak > 0 ? 2'b01 : 2'b00);
    w.stallcount = mStalls;
    w.flushcount = mFlushes;
    q.push_back(w);

    if (s.reset) begin
      streak   = 0;
      trapped  = 0;
      mStalls  = 0;
      mFlushes = 0;
    end else begin
      if (!trapped) begin
        if (memStall) begin
          streak++;
          if (streak > TIMEOUT) trapped = 1;
        end else streak = 0;
      end
      if (w.stall[3] && mStalls != 32'hFFFF_FFFF) mStalls++;
      if (branch && mFlushes != 32'hFFFF_FFFF) mFlushes++;
    end
  endtask

  // Monitor: every cycle presents a full set of outputs; compare against the oldest prediction.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      want_t w;
      w = q.pop_front();
      checkOutput("ForwardAE", 32'(hz.ForwardAE), 32'(w.fwda));
      checkOutput("ForwardBE", 32'(hz.ForwardBE), 32'(w.fwdb));
      checkOutput("StallFDEM", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'(w.stall));
      checkOutput("FlushDEW", 32'({hz.FlushD, hz.FlushE, hz.FlushW}), 32'(w.flush));
      checkOutput("MemTimeout", 32'(hz.MemTimeout), 32'(w.memtimeout));
      checkOutput("HzState", 32'(hz.HzState), 32'(w.hzstate));
`ifdef HAZARD_PERF_EN
      checkOutput("StallCount", stallCount, w.stallcount);
      checkOutput("FlushCount", flushCount, w.flushcount);
`endif
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.reset      = ($urandom_range(0, 63) == 0);
    s.rs1d       = 5'($urandom_range(0, 7));
    s.rs2d       = 5'($urandom_range(0, 7));
    s.rs1e       = 5'($urandom_range(0, 7));
    s.rs2e       = 5'($urandom_range(0, 7));
    s.rde        = 5'($urandom_range(0, 7));
    s.rdm        = 5'($urandom_range(0, 7));
    s.rdw        = 5'($urandom_range(0, 7));
    s.resultsrce = 2'($urandom_range(0, 3));
    s.regwritem  = 1'($urandom_range(0, 1));
    s.regwritew  = 1'($urandom_range(0, 1));
    s.pcsrce     = ($urandom_range(0, 3) == 0);
    s.memreqm    = ($urandom_range(0, 2) == 0);
    s.memreadym  = ($urandom_range(0, 2) != 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1;
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.RdM = 0; hz.RdW = 0; hz.ResultSrcE = 0; hz.RegWriteM = 0;
    hz.RegWriteW = 0; hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;

    s = idle(); s.reset = 1;
    applyStimulus(s);
    applyStimulus(s);

    // Forwarding priority and r0 exclusion.
    s = idle(); s.rdm = 5; s.regwritem = 1; s.rdw = 5; s.regwritew = 1; s.rs1e = 5;
    applyStimulus(s);
    s.rdm = 0;
    applyStimulus(s);
    s.rs2e = 0; s.rdw = 0;
    applyStimulus(s);

    // Load-use, then the load in M forwards to B.
    s = idle(); s.resultsrce = 2'b01; s.rde = 7; s.rs2d = 7;
    applyStimulus(s);
    s = idle(); s.rdm = 7; s.regwritem = 1; s.rs2e = 7;
    applyStimulus(s);

    // Branch wins over a simultaneous load-use.
    s = idle(); s.pcsrce = 1; s.resultsrce = 2'b01; s.rde = 7; s.rs2d = 7;
    applyStimulus(s);

    // Three-cycle memory wait with a branch pending, then release.
    s = idle(); s.memreqm = 1; s.memreadym = 0; s.pcsrce = 1;
    repeat (3) applyStimulus(s);
    s.memreadym = 1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Second load-use so the stall counter sees 2 + 3.
    s = idle(); s.resultsrce = 2'b01; s.rde = 3; s.rs1d = 3;
    applyStimulus(s);
    applyStimulus(idle());

    // Timeout into trap, sticky, then cleared by reset.
    s = idle(); s.memreqm = 1; s.memreadym = 0;
    repeat (8) applyStimulus(s);
    repeat (2) applyStimulus(idle());
    s = idle(); s.reset = 1; s.pcsrce = 1; s.memreqm = 1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    // Back-to-back misses separated by a single ready cycle.
    s = idle(); s.memreqm = 1;
    repeat (4) applyStimulus(s);
    s.memreadym = 1;
    applyStimulus(s);
    s.memreadym = 0;
    repeat (4) applyStimulus(s);
    s.memreqm = 0;
    applyStimulus(s);

    for (int i = 0; i < 2000; i++) applyStimulus(randStim());

    repeat (3) @(posedge clk);
    checkOutput("queueDrained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
